// File: rtl/pipe_stage_hs.sv
// Purpose: one-entry valid/ready pipeline register carrying payload, control word and instruction.
// Latency: one cycle from input acceptance to out_valid_o; a drain and a refill on the same edge leave no bubble.
// Backpressure: in_ready_o = ~out_valid_o | out_ready_i, or registered "skid empty" when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_hs #(
    parameter int          DATA_WIDTH = 133,
    parameter int          CTRL_WIDTH = 16,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    input  logic [31:0]           instr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o,
    output logic [31:0]           instr_o,
    output logic [15:0]           stall_cnt_o
);

    // Main entry. ctrl/instr are cleared to 0/NOP whenever the entry empties,
    // so the outputs need no extra masking. data keeps its last value.
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [31:0]           r_instr;
    logic [15:0]           r_stall_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_main_free;
    logic w_stalled;

    assign w_out_fire  = r_valid & out_ready_i;
    assign w_main_free = ~r_valid | out_ready_i;
    assign w_stalled   = r_valid & ~out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry catches a beat accepted while the main entry is stuck.
    logic                  r_skid_vld;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [31:0]           r_skid_instr;

    assign in_ready_o = ~r_skid_vld;
    assign w_in_fire  = in_valid_i & ~r_skid_vld;

    // Main entry refill: skid has priority over the input so order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                r_valid <= 1'b1;
                r_data  <= r_skid_data;
                r_ctrl  <= r_skid_ctrl;
                r_instr <= r_skid_instr;
            end else if (w_in_fire) begin
                r_valid <= 1'b1;
                r_data  <= data_i;
                r_ctrl  <= ctrl_i;
                r_instr <= instr_i;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_instr <= NOP_INSTR;
            end
        end
    end

    // Skid fill when the main entry is held, empty as soon as the main entry frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_vld   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_skid_instr <= NOP_INSTR;
        end else if (flush_i) begin
            r_skid_vld <= 1'b0;
        end else if (w_main_free) begin
            r_skid_vld <= 1'b0;
        end else if (w_in_fire) begin
            r_skid_vld   <= 1'b1;
            r_skid_data  <= data_i;
            r_skid_ctrl  <= ctrl_i;
            r_skid_instr <= instr_i;
        end
    end
`else
    assign in_ready_o = w_main_free;
    assign w_in_fire  = in_valid_i & w_main_free;

    // Main entry: flush wins, then load on accept, else empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
            r_ctrl  <= ctrl_i;
            r_instr <= instr_i;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_instr <= NOP_INSTR;
        end
    end
`endif

    // Saturating count of back-pressured cycles; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stalled && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign out_valid_o = r_valid;
    assign data_o      = r_data;
    assign ctrl_o      = r_ctrl;
    assign instr_o     = r_instr;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Purpose: randomized and directed checks of pipe_stage_hs against a queue-based model.
// Latency: model advances once per clock edge; outputs compared on the falling edge.
// Backpressure: model occupancy limit is 1 entry, or 2 when PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_hs;
    localparam int          DW  = 133;
    localparam int          CW  = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] data_i = '0;
    logic [CW-1:0] ctrl_i = '0;
    logic [31:0]   instr_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] data_o;
    logic [CW-1:0] ctrl_o;
    logic [31:0]   instr_o;
    logic [15:0]   stall_cnt_o;

    pipe_stage_hs #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .ctrl_i(ctrl_i), .instr_i(instr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .ctrl_o(ctrl_o), .instr_o(instr_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [31:0]   instr;
    } beat_t;

    // Model: ordered list of beats held by the stage; head is what the outputs show.
    beat_t         q[$];
    logic [15:0]   m_stall;
    logic [DW-1:0] m_data;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic m_in_ready(input logic orr);
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || orr;
`endif
    endfunction

    function automatic beat_t rand_beat();
        logic [159:0] t;
        beat_t b;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b.data  = t[DW-1:0];
        b.ctrl  = CW'($urandom);
        b.instr = $urandom;
        return b;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ":vld"},   160'(out_valid_o), 160'(q.size() > 0));
        chk({tag, ":ctrl"},  160'(ctrl_o),  160'((q.size() > 0) ? q[0].ctrl : '0));
        chk({tag, ":instr"}, 160'(instr_o), 160'((q.size() > 0) ? q[0].instr : NOP));
        chk({tag, ":data"},  160'(data_o),  160'(m_data));
        chk({tag, ":stall"}, 160'(stall_cnt_o), 160'(m_stall));
    endtask

    // Drive one cycle of inputs from a falling edge, advance the model at the rising edge.
    task automatic step(input logic iv, input logic orr, input logic fl, input beat_t b);
        logic acc, pop, stl;
        in_valid_i  = iv;
        out_ready_i = orr;
        flush_i     = fl;
        data_i      = b.data;
        ctrl_i      = b.ctrl;
        instr_i     = b.instr;
        #1;
        chk("rdy", 160'(in_ready_o), 160'(m_in_ready(orr)));
        acc = iv && m_in_ready(orr);
        pop = (q.size() > 0) && orr;
        stl = (q.size() > 0) && !orr;
        @(posedge clk);
        if (stl && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        if (q.size() > 0) m_data = q[0].data;
        @(negedge clk);
        check_outs("step");
    endtask

    task automatic model_reset();
        q.delete();
        m_stall = 16'h0000;
        m_data  = '0;
    endtask

    initial begin
        beat_t b;
        beat_t saved;
        int    n;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("in_reset");
        rst_n = 1'b1;
        #1;
        chk("r036_vld",   160'(out_valid_o), 160'(0));
        chk("r036_ctrl",  160'(ctrl_o),      160'(0));
        chk("r036_instr", 160'(instr_o),     160'(32'h00000013));
        chk("r036_stall", 160'(stall_cnt_o), 160'(0));
        @(negedge clk);

        // Single beat, one-cycle latency
        b = rand_beat();
        b.instr = 32'h00A00093;
        b.ctrl  = 16'h0005;
        step(1'b1, 1'b1, 1'b0, b);
        chk("r037_vld",   160'(out_valid_o), 160'(1));
        chk("r037_instr", 160'(instr_o),     160'(32'h00A00093));
        chk("r037_ctrl",  160'(ctrl_o),      160'(16'h0005));

        // Continuous stream: every cycle shows the beat accepted on the previous edge
        for (int i = 0; i < 8; i++) begin
            b = rand_beat();
            step(1'b1, 1'b1, 1'b0, b);
            chk("stream_vld",   160'(out_valid_o), 160'(1));
            chk("stream_instr", 160'(instr_o),     160'(b.instr));
        end

        // Back-pressure for three cycles: head held stable
        saved = b;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, rand_beat());
            chk("r038_instr", 160'(instr_o), 160'(saved.instr));
            chk("r038_data",  160'(data_o),  160'(saved.data));
        end
`ifndef PIPE_STAGE_SKID_EN
        chk("r038_rdy", 160'(in_ready_o), 160'(0));
`endif
        chk("r038_stall", 160'(stall_cnt_o), 160'(3));

        // Flush beats a simultaneous transfer; incoming beat is lost
        step(1'b1, 1'b1, 1'b1, rand_beat());
        chk("r039_vld",   160'(out_valid_o), 160'(0));
        chk("r039_instr", 160'(instr_o),     160'(NOP));
        chk("r039_stall", 160'(stall_cnt_o), 160'(3));
        step(1'b0, 1'b1, 1'b0, rand_beat());
        chk("r039_lost",  160'(out_valid_o), 160'(0));

        // Reset in the middle of a held beat, then accept on the first edge after release
        step(1'b1, 1'b0, 1'b0, rand_beat());
        in_valid_i = 1'b1;
        rst_n      = 1'b0;
        #1;
        model_reset();
        check_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        b = rand_beat();
        step(1'b1, 1'b0, 1'b0, b);
        chk("rst_accept", 160'(instr_o), 160'(b.instr));

`ifdef PIPE_STAGE_SKID_EN
        // A then B under back-pressure: B lands in the skid, ready drops, order kept on drain
        step(1'b1, 1'b1, 1'b1, rand_beat());
        begin
            beat_t ba, bb;
            ba = rand_beat();
            bb = rand_beat();
            step(1'b1, 1'b0, 1'b0, ba);
            step(1'b1, 1'b0, 1'b0, bb);
            chk("skid_rdy_lo", 160'(in_ready_o), 160'(0));
            step(1'b0, 1'b1, 1'b0, rand_beat());
            chk("skid_a", 160'(instr_o), 160'(bb.instr));
            chk("skid_rdy_hi", 160'(in_ready_o), 160'(1));
        end
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 100) < 3, rand_beat());
        end

        // Stall counter saturation
        step(1'b1, 1'b1, 1'b0, rand_beat());
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        n = 32'hFFFE - int'(m_stall);
        if (n > 0) begin
            repeat (n) @(posedge clk);
        end
        m_stall = 16'hFFFE;
        @(negedge clk);
        chk("sat_fffe", 160'(stall_cnt_o), 160'(16'hFFFE));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, rand_beat());
        chk("sat_ffff", 160'(stall_cnt_o), 160'(16'hFFFF));
        step(1'b0, 1'b1, 1'b1, rand_beat());
        chk("flush_keeps_cnt", 160'(stall_cnt_o), 160'(16'hFFFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 133, width of the bundled payload (pc, pc_incr, rs1 data, rs2 data, rd port).
REQ-002 The block SHALL expose parameter CTRL_WIDTH, default 16, width of the control word.
REQ-003 The block SHALL expose parameter NOP_INSTR, default 32'h00000013, the instruction word presented while empty.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous flush; discards all held and incoming beats.
REQ-007 in_valid_i  input  1  upstream beat valid.
REQ-008 in_ready_o  output  1  stage can accept a beat this cycle.
REQ-009 data_i  input  DATA_WIDTH  upstream payload.
REQ-010 ctrl_i  input  CTRL_WIDTH  upstream control word.
REQ-011 instr_i  input  32  upstream instruction.
REQ-012 out_valid_o  output  1  downstream beat valid.
REQ-013 out_ready_i  input  1  downstream accepts the beat.
REQ-014 data_o  output  DATA_WIDTH  held payload.
REQ-015 ctrl_o  output  CTRL_WIDTH  held control word.
REQ-016 instr_o  output  32  held instruction.
REQ-017 stall_cnt_o  output  16  count of back-pressured cycles.

Function
REQ-018 An input transfer SHALL occur when in_valid_i and in_ready_o are both 1 at a rising edge; an output transfer SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-019 Without skid, in_ready_o SHALL equal (~out_valid_o | out_ready_i), combinationally.
REQ-020 Latency SHALL be one cycle: a beat accepted at edge N SHALL appear on the outputs with out_valid_o=1 after edge N.
REQ-021 A beat SHALL be held stable on data_o/ctrl_o/instr_o while out_valid_o=1 and out_ready_i=0.
REQ-022 Simultaneous input and output transfer SHALL replace the held beat with the new one, with no bubble.
REQ-023 While out_valid_o=0, ctrl_o SHALL be 0 and instr_o SHALL be NOP_INSTR; data_o SHALL hold its last value.
REQ-024 On an output transfer with no input transfer, out_valid_o SHALL go to 0 and ctrl_o/instr_o SHALL go to 0/NOP_INSTR.
REQ-025 flush_i=1 SHALL, at the next edge, clear out_valid_o, zero ctrl_o and set instr_o=NOP_INSTR; a beat presented in the same cycle SHALL be discarded.
REQ-026 flush_i SHALL take priority over every simultaneous transfer.
REQ-027 stall_cnt_o SHALL increment by 1 on each edge where out_valid_o=1 and out_ready_i=0, and SHALL saturate at 16'hFFFF.
REQ-028 flush_i SHALL NOT modify stall_cnt_o.

Reset
REQ-029 While rst_n=0: out_valid_o=0, ctrl_o=0, instr_o=NOP_INSTR, data_o=0, stall_cnt_o=0, and all skid state is empty.
REQ-030 Assertion mid-transfer SHALL abandon the in-flight beat; the first acceptance after release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined SHALL add a one-entry skid buffer, making in_ready_o a registered output equal to "skid empty".
REQ-032 With the skid buffer, a beat accepted while the main entry is held and not drained SHALL enter the skid, and in_ready_o SHALL drop on the following cycle.
REQ-033 With the skid buffer, on drain the skid beat SHALL move to the main entry next cycle, and in_ready_o SHALL rise when the skid empties; beat order SHALL be preserved.
REQ-034 With the skid buffer, flush_i SHALL clear both entries.
REQ-035 With the macro undefined, the block SHALL behave per REQ-019 with no skid storage.

Verification
REQ-036 Reset released, no input -> out_valid_o=0, ctrl_o=0, instr_o=32'h00000013, stall_cnt_o=0.
REQ-037 Accept instr_i=32'h00A00093, ctrl_i=16'h0005 with out_ready_i=1 -> next cycle out_valid_o=1, instr_o=32'h00A00093, ctrl_o=16'h0005; a continuous stream passes with no bubbles.
REQ-038 Hold out_ready_i=0 for 3 cycles with a valid beat -> outputs stable, in_ready_o=0 (no skid), stall_cnt_o=3.
REQ-039 Assert flush_i with out_valid_o=1 and in_valid_i=1 -> next cycle out_valid_o=0, instr_o=NOP_INSTR, incoming beat lost, stall_cnt_o unchanged.
REQ-040 Force stall_cnt_o to 16'hFFFE and back-pressure 3 cycles -> stall_cnt_o holds at 16'hFFFF.
REQ-041 With PIPE_STAGE_SKID_EN: send beats A, B while out_ready_i=0 -> in_ready_o=0 after B; release out_ready_i -> A then B delivered in order, in_ready_o=1 once B reaches the main entry.
